// File: rtl/i2s_capture_sdram_if.sv
// Write-client port between the I2S capture block and the SDRAM arbiter.
// The capture block is the master; the arbiter side is the slave.
interface i2s_capture_sdram_if;
  logic         sdram_wait;
  logic         sdram_ac;
  logic         sdram_wr;
  logic [21:0]  sdram_addr;
  logic [127:0] sdram_data;
  logic [15:0]  sdram_be;

  modport master (
    input  sdram_wait, sdram_ac,
    output sdram_wr, sdram_addr, sdram_data, sdram_be
  );

  modport slave (
    output sdram_wait, sdram_ac,
    input  sdram_wr, sdram_addr, sdram_data, sdram_be
  );
endinterface

// File: rtl/i2s_capture_sdram.sv
// I2S ADC capture: packs four stereo 16-bit frames per 128-bit word and
// writes each word into an SDRAM ring buffer through a 2-deep ping-pong FIFO.
module i2s_capture_sdram #(
  parameter logic [21:0] BASE_ADDR  = 22'h200000,
  parameter int unsigned RING_WORDS = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       SClk,
  input  logic                       LRClk,
  input  logic                       Din,
  i2s_capture_sdram_if.master        sdram,
  output logic                       busy,
  output logic                       overflow,
  output logic [15:0]                wr_count
);
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned WORD_W   = 128;
  localparam int unsigned PTR_W    = (RING_WORDS > 1) ? $clog2(RING_WORDS) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  logic [1:0]          sclk_sync, lr_sync, din_sync;
  logic                sclk_old;
  logic                sclk_rise_c, lr_now, din_now;

  logic                lr_prev, chan;
  logic [4:0]          bit_cnt;
  logic [SAMPLE_W-1:0] shreg, sample_c;
  logic                sample_done_c, lr_fall_c;

  logic                cap_active, have_left;
  logic [SAMPLE_W-1:0] left_s;
  logic [1:0]          frame_cnt;
  logic [95:0]         word_acc;
  logic                word_done_c;
  logic [WORD_W-1:0]   word_c;

  logic [WORD_W-1:0]   slot_q [2];
  logic [1:0]          slot_cnt, cnt_pop_c, cnt_nxt_c;
  logic                head, head_pop_c, widx_c;
  logic                pop_c, push_c, drop_c;

  state_t              state, state_nxt;
  logic                wr_nxt, load_c;
  logic [PTR_W-1:0]    wptr;

  // SClk/LRClk/Din synchronizers; sclk_old gives the edge-detect history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      lr_sync   <= '0;
      din_sync  <= '0;
      sclk_old  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], SClk};
      lr_sync   <= {lr_sync[0], LRClk};
      din_sync  <= {din_sync[0], Din};
      sclk_old  <= sclk_sync[1];
    end
  end

  assign sclk_rise_c   = sclk_sync[1] & ~sclk_old;
  assign lr_now        = lr_sync[1];
  assign din_now       = din_sync[1];
  assign sample_c      = {shreg[SAMPLE_W-2:0], din_now};
  assign sample_done_c = sclk_rise_c && (bit_cnt == 5'd1);
  assign lr_fall_c     = sclk_rise_c && lr_prev && !lr_now;

  // A word-select change re-arms the counter after any in-flight bit is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lr_prev <= 1'b0;
      chan    <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (sclk_rise_c) begin
      lr_prev <= lr_now;
      if (bit_cnt != 5'd0) begin
        shreg   <= sample_c;
        bit_cnt <= bit_cnt - 5'd1;
      end
      if (lr_now != lr_prev) begin
        bit_cnt <= 5'd16;
        chan    <= lr_now;
      end
    end
  end

  assign word_done_c = enable && cap_active && sample_done_c && chan &&
                       have_left && (frame_cnt == 2'd3);
  assign word_c      = {word_acc, left_s, sample_c};

  // Frame assembly; capture starts only at a left slot following a right slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_active <= 1'b0;
      have_left  <= 1'b0;
      left_s     <= '0;
      frame_cnt  <= '0;
      word_acc   <= '0;
    end else if (!enable) begin
      cap_active <= 1'b0;
      have_left  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (lr_fall_c) cap_active <= 1'b1;
      if (cap_active && sample_done_c) begin
        if (!chan) begin
          left_s    <= sample_c;
          have_left <= 1'b1;
        end else if (have_left) begin
          have_left <= 1'b0;
          word_acc  <= {word_acc[63:0], left_s, sample_c};
          frame_cnt <= frame_cnt + 2'd1;
        end
      end
    end
  end

  // Pop is applied before push so an accept frees a slot for a same-cycle word
  always_comb begin
    pop_c      = (state == REQ) && sdram.sdram_ac;
    cnt_pop_c  = slot_cnt - 2'(pop_c);
    head_pop_c = head ^ pop_c;
    push_c     = word_done_c && (cnt_pop_c != 2'd2);
    drop_c     = word_done_c && (cnt_pop_c == 2'd2);
    widx_c     = head_pop_c ^ cnt_pop_c[0];
    cnt_nxt_c  = cnt_pop_c + 2'(push_c);
  end

  always_ff @(posedge clk) begin
    if (push_c) slot_q[widx_c] <= word_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_nxt    = 1'b0;
    load_c    = 1'b0;
    case (state)
      IDLE: begin
        if (slot_cnt != 2'd0) begin
          state_nxt = REQ;
          wr_nxt    = 1'b1;
          load_c    = 1'b1;
        end
      end
      REQ: begin
        if (sdram.sdram_ac) state_nxt = IDLE;
        else                wr_nxt    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt         <= '0;
      head             <= 1'b0;
      overflow         <= 1'b0;
      wptr             <= '0;
      wr_count         <= '0;
      busy             <= 1'b0;
      sdram.sdram_wr   <= 1'b0;
      sdram.sdram_be   <= '0;
      sdram.sdram_addr <= BASE_ADDR;
      sdram.sdram_data <= '0;
    end else begin
      slot_cnt       <= cnt_nxt_c;
      head           <= head_pop_c;
      busy           <= (cnt_nxt_c != 2'd0) || wr_nxt;
      sdram.sdram_wr <= wr_nxt;
      sdram.sdram_be <= wr_nxt ? 16'hFFFF : 16'h0000;
      if (drop_c) overflow <= 1'b1;
      if (load_c) begin
        sdram.sdram_addr <= BASE_ADDR + 22'(wptr);
        sdram.sdram_data <= slot_q[head];
      end
      if (pop_c) begin
        wptr     <= wptr + PTR_W'(1);
        wr_count <= wr_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_i2s_capture_sdram.sv
// Scoreboard bench: frame-level model predicts written words; two DUTs share
// the I2S stream (4096-word ring with scripted acks, 4-word ring with instant acks).
module tb_i2s_capture_sdram;
  localparam logic [21:0] BASE = 22'h200000;

  logic clk = 1'b0;
  logic reset, enable, SClk, LRClk, Din;
  logic busy1, ovf1, busy2, ovf2;
  logic [15:0] cnt1, cnt2;

  i2s_capture_sdram_if if1 ();
  i2s_capture_sdram_if if2 ();

  i2s_capture_sdram #(.BASE_ADDR(BASE), .RING_WORDS(4096)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .SClk(SClk), .LRClk(LRClk), .Din(Din),
    .sdram(if1), .busy(busy1), .overflow(ovf1), .wr_count(cnt1));

  i2s_capture_sdram #(.BASE_ADDR(BASE), .RING_WORDS(4)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .SClk(SClk), .LRClk(LRClk), .Din(Din),
    .sdram(if2), .busy(busy2), .overflow(ovf2), .wr_count(cnt2));

  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] q1[$];
  logic [127:0] q2[$];
  logic [31:0]  mframes[$];
  bit mcap = 1'b0;
  bit ack_en1 = 1'b1;
  bit force_wait1 = 1'b0;
  int half = 160;
  int n1 = 0;
  int n2 = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One 32-bit I2S slot: data changes on SClk fall, MSB one bit after LRClk change
  task automatic drive_slot(input logic lr, input logic [15:0] v, input int en_at);
    for (int i = 0; i < 32; i++) begin
      SClk  = 1'b0;
      LRClk = lr;
      Din   = (i >= 1 && i <= 16) ? v[4'(16 - i)] : 1'($urandom);
      if (i == en_at) enable = 1'b1;
      #(half);
      SClk = 1'b1;
      #(half);
    end
  endtask

  // Model: capture begins at a left slot seen with enable high; 4 frames make a word
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int en_at);
    logic [127:0] w;
    if (enable && !mcap) mcap = 1'b1;
    drive_slot(1'b0, l, -1);
    if (mcap) begin
      mframes.push_back({l, r});
      if (mframes.size() == 4) begin
        w = {mframes[0], mframes[1], mframes[2], mframes[3]};
        mframes.delete();
        q2.push_back(w);
        if (q1.size() < 2) q1.push_back(w);
      end
    end
    drive_slot(1'b1, r, en_at);
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_frame(16'($urandom), 16'($urandom), -1);
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    mcap   = 1'b0;
    mframes.delete();
  endtask

  task automatic drain();
    int i = 0;
    while ((q1.size() != 0 || q2.size() != 0) && i < 5000) begin
      @(negedge clk);
      i++;
    end
    repeat (4) @(negedge clk);
    check("drain", 128'(q1.size() + q2.size()), 128'd0);
  endtask

  task automatic wait_wr1();
    int i = 0;
    while (!if1.sdram_wr && i < 20000) begin
      @(negedge clk);
      i++;
    end
    check("wr1_rise", 128'(if1.sdram_wr), 128'd1);
  endtask

  // Arbiter model for dut1: scripted wait/ack latency, can withhold ack
  initial begin
    int wc;
    int dly;
    wc = 0;
    dly = 2;
    if1.sdram_ac = 1'b0;
    if1.sdram_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (if1.sdram_ac) begin
        if1.sdram_ac = 1'b0;
        if1.sdram_wait = 1'b0;
        wc = 0;
      end else if (if1.sdram_wr) begin
        if1.sdram_wait = force_wait1 || (wc < dly);
        if (ack_en1 && !if1.sdram_wait) begin
          if1.sdram_ac = 1'b1;
          dly = $urandom_range(0, 3);
        end else wc++;
      end else begin
        if1.sdram_wait = 1'b0;
        wc = 0;
      end
    end
  end

  initial begin
    if2.sdram_ac = 1'b0;
    if2.sdram_wait = 1'b0;
    forever begin
      @(negedge clk);
      if2.sdram_ac = if2.sdram_ac ? 1'b0 : if2.sdram_wr;
    end
  end

  // dut1 monitor: request stability, address sequence, data vs scoreboard
  initial begin
    logic [21:0] ha;
    logic [127:0] hd;
    bit inreq;
    bit unst;
    inreq = 1'b0;
    unst = 1'b0;
    ha = '0;
    hd = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) inreq = 1'b0;
      else if (if1.sdram_wr) begin
        if (!inreq) begin
          inreq = 1'b1;
          unst = 1'b0;
          ha = if1.sdram_addr;
          hd = if1.sdram_data;
        end else if (if1.sdram_addr != ha || if1.sdram_data != hd || if1.sdram_be != 16'hFFFF)
          unst = 1'b1;
        if (if1.sdram_ac) begin
          inreq = 1'b0;
          check("hold1", 128'(unst), 128'd0);
          check("be1", 128'(if1.sdram_be), 128'hFFFF);
          check("addr1", 128'(if1.sdram_addr), 128'(BASE + 22'(n1 % 4096)));
          if (q1.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL write1: unexpected word %h", if1.sdram_data);
          end else check("data1", if1.sdram_data, q1.pop_front());
          n1++;
          @(negedge clk);
          #2;
          check("release1", 128'(if1.sdram_wr), 128'd0);
          check("wr_count1", 128'(cnt1), 128'(16'(n1)));
        end
      end
    end
  end

  // dut2 monitor: 4-word ring wrap
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && if2.sdram_wr && if2.sdram_ac) begin
        check("addr2", 128'(if2.sdram_addr), 128'(BASE + 22'(n2 % 4)));
        if (q2.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL write2: unexpected word %h", if2.sdram_data);
        end else check("data2", if2.sdram_data, q2.pop_front());
        n2++;
        @(negedge clk);
        #2;
        check("wr_count2", 128'(cnt2), 128'(16'(n2)));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    SClk = 1'b0;
    LRClk = 1'b1;
    Din = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr", 128'(if1.sdram_wr), 128'd0);
    check("rst_addr", 128'(if1.sdram_addr), 128'(BASE));
    check("rst_data", if1.sdram_data, 128'd0);
    check("rst_be", 128'(if1.sdram_be), 128'd0);
    check("rst_busy", 128'(busy1), 128'd0);
    check("rst_ovf", 128'(ovf1), 128'd0);
    check("rst_cnt", 128'(cnt1), 128'd0);
    reset = 1'b0;
    enable = 1'b1;

    // single word at 3.125 MHz SClk
    drive_slot(1'b1, 16'h0000, -1);
    for (int k = 1; k <= 4; k++) send_frame(16'(k * 'h1111), 16'(16'hA000 + k), -1);
    drain();
    half = 85;

    // held request with wait asserted
    ack_en1 = 1'b0;
    force_wait1 = 1'b1;
    send_random(4);
    wait_wr1();
    repeat (500) @(negedge clk);
    check("held_wr", 128'(if1.sdram_wr), 128'd1);
    ack_en1 = 1'b1;
    force_wait1 = 1'b0;
    drain();

    // overflow: three words with no ack
    ack_en1 = 1'b0;
    check("ovf_before", 128'(ovf1), 128'd0);
    send_random(12);
    repeat (10) @(negedge clk);
    check("ovf_after", 128'(ovf1), 128'd1);
    check("busy_full", 128'(busy1), 128'd1);
    ack_en1 = 1'b1;
    drain();

    // enable gating: partial word discarded, restart at next left slot
    send_random(2);
    drop_enable();
    repeat (20) @(negedge clk);
    send_random(1);
    send_frame(16'($urandom), 16'($urandom), 10);
    send_random(4);
    drain();

    send_random(8);
    drain();
    check("ovf2", 128'(ovf2), 128'd0);
    check("idle_busy", 128'(busy1), 128'd0);

    // asynchronous reset while a request is pending
    ack_en1 = 1'b0;
    send_random(4);
    wait_wr1();
    repeat (20) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_wr", 128'(if1.sdram_wr), 128'd0);
    check("mid_rst_addr", 128'(if1.sdram_addr), 128'(BASE));
    check("mid_rst_data", if1.sdram_data, 128'd0);
    check("mid_rst_be", 128'(if1.sdram_be), 128'd0);
    check("mid_rst_busy", 128'(busy1), 128'd0);
    check("mid_rst_ovf", 128'(ovf1), 128'd0);
    check("mid_rst_cnt", 128'(cnt1), 128'd0);
    q1.delete();
    q2.delete();
    mframes.delete();
    mcap = 1'b0;
    n1 = 0;
    n2 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("post_rst_wr", 128'(if1.sdram_wr), 128'd0);
    check("post_rst_busy", 128'(busy1), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
